// File: rtl/rr_arbiter8.sv
// Eight-input round-robin arbiter with a registered one-hot grant, per-grant
// hold timeout and priority rotation to the index after the last winner.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       release_pulse,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout
);
    localparam int CNT_W = $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]       state_reg, state_next;
    logic [2:0]       ptr_reg, ptr_next;
    logic [2:0]       gidx_reg, gidx_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [7:0]       grant_reg, grant_next;
    logic             busy_reg;
    logic             timeout_reg, timeout_next;

    // Requests rotated so that bit 0 is the current highest-priority index.
    logic [7:0] req_rot;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign req_rot[gi] = req[3'(gi) + ptr_reg];
        end
    endgenerate

    logic [2:0] pick_off;
    logic [2:0] pick_idx;
    always_comb begin
        pick_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) pick_off = 3'(i);
        end
        pick_idx = pick_off + ptr_reg;
    end

    logic rel_cause;
    logic at_limit;
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        gidx_next     = gidx_reg;
        hold_cnt_next = hold_cnt_reg;
        grant_next    = grant_reg;
        timeout_next  = 1'b0;
        rel_cause     = release_pulse || !req[gidx_reg];
        at_limit      = (hold_cnt_reg == CNT_LAST);
        case (state_reg)
            IDLE: begin
                grant_next = 8'h00;
                if (|req) begin
                    grant_next    = 8'h01 << pick_idx;
                    gidx_next     = pick_idx;
                    hold_cnt_next = '0;
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                if (rel_cause || at_limit) begin
                    grant_next   = 8'h00;
                    ptr_next     = gidx_reg + 3'd1;
                    state_next   = IDLE;
                    // A forced release is only flagged when nothing else ended the grant.
                    timeout_next = at_limit && !rel_cause;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= 3'd0;
            gidx_reg     <= 3'd0;
            hold_cnt_reg <= '0;
            grant_reg    <= 8'h00;
            busy_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            gidx_reg     <= gidx_next;
            hold_cnt_reg <= hold_cnt_next;
            grant_reg    <= grant_next;
            busy_reg     <= |grant_next;
            timeout_reg  <= timeout_next;
        end
    end

    assign grant   = grant_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;
endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: stimulus pushes model predictions,
// a monitor pops and compares one entry per clock.
module tb_rr_arbiter8;
    localparam int HOLD_MAX = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       release_pulse = 1'b0;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    rr_arbiter8 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .release_pulse(release_pulse),
        .grant(grant),
        .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] grant;
        logic       busy;
        logic       timeout;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn = 0;

    // Reference model: who owns the bus, how many cycles it has held it, and
    // where the next search starts.
    int m_owner = -1;
    int m_hold = 0;
    int m_ptr = 0;

    task automatic cyc(input logic [7:0] r, input logic rel, input logic rn);
        exp_t e;
        logic to;
        @(negedge clk);
        req = r;
        release_pulse = rel;
        rst_n = rn;
        to = 1'b0;
        if (!rn) begin
            m_owner = -1;
            m_hold = 0;
            m_ptr = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 8; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_hold = 1;
                end
            end
        end else begin
            if (rel || !r[m_owner] || m_hold == HOLD_MAX) begin
                to = (m_hold == HOLD_MAX) && !rel && r[m_owner];
                m_ptr = (m_owner + 1) % 8;
                m_owner = -1;
                m_hold = 0;
            end else begin
                m_hold++;
            end
        end
        e.grant = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        e.busy = (m_owner >= 0);
        e.timeout = to;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: req=%02h rel=%0b rst_n=%0b grant=%02h busy=%0b timeout=%0b exp=%02h/%0b/%0b",
                         txn, req, release_pulse, rst_n, grant, busy, timeout, e.grant, e.busy, e.timeout);
                checks++;
                if (grant !== e.grant) begin
                    errors++;
                    $display("FAIL grant txn %0d: got %02h expected %02h", txn, grant, e.grant);
                end
                checks++;
                if (busy !== e.busy) begin
                    errors++;
                    $display("FAIL busy txn %0d: got %0b expected %0b", txn, busy, e.busy);
                end
                checks++;
                if (timeout !== e.timeout) begin
                    errors++;
                    $display("FAIL timeout txn %0d: got %0b expected %0b", txn, timeout, e.timeout);
                end
                checks++;
                if ($countones(grant) > 1) begin
                    errors++;
                    $display("FAIL onehot txn %0d: got %02h expected at most one bit", txn, grant);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset with all requests pending, then release reset.
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'hFF, 1'b0, 1'b1);
        // Rotation: release in every granted cycle, two full laps.
        for (int i = 0; i < 34; i++) cyc(8'hFF, (m_owner >= 0), 1'b1);
        // Fairness across a gap in the request vector.
        cyc(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(8'h81, (m_owner >= 0), 1'b1);
        // Timeout: single requester, no release; two full timeouts.
        cyc(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cyc(8'h10, 1'b0, 1'b1);
        // Requester drop mid-grant.
        cyc(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(8'h04, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cyc(8'h00, 1'b0, 1'b1);
        // Release coinciding with the last allowed cycle: no timeout pulse.
        for (int i = 0; i < 20; i++) cyc(8'h04, (m_owner >= 0 && m_hold == HOLD_MAX), 1'b1);
        // Reset mid-grant, then pointer must be back at 0.
        cyc(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(8'h20, 1'b0, 1'b1);
        cyc(8'h21, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(8'h21, 1'b0, 1'b1);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 2) != 0) r[m_owner] = 1'b1;
            cyc(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 63) != 0));
        end
        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
